// File: rtl/frame_phase_sequencer.sv
// Per-frame ERASE -> UPDATE -> DRAW sequencer driven by the 30 Hz frame tick.
// Optional per-phase watchdog enabled by defining PHASE_TIMEOUT_EN.
module frame_phase_sequencer #(
  parameter int unsigned FRAMES_PER_SEC = 30,
  parameter int unsigned FRAME_W        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               frame_tick,
  output logic               erase_start,
  input  logic               erase_done,
  output logic               update_start,
  input  logic               update_done,
  output logic               draw_start,
  input  logic               draw_done,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_count,
  output logic               overrun,
  output logic [7:0]         overrun_count,
  output logic               timeout
);

  typedef enum logic [1:0] {StIdle, StErase, StUpdate, StDraw} state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic               r_erase_start;
  logic               r_update_start;
  logic               r_draw_start;
  logic               r_busy;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_overrun;
  logic [7:0]         r_overrun_count;
  logic               r_timeout;

  logic               w_erase_start_d;
  logic               w_update_start_d;
  logic               w_draw_start_d;
  logic               w_busy_d;
  logic [FRAME_W-1:0] w_frame_count_d;
  logic               w_overrun_d;
  logic [7:0]         w_overrun_count_d;

  logic               w_erase_acc;
  logic               w_update_acc;
  logic               w_draw_acc;
  logic               w_done_acc;
  logic               w_drop;
  logic               w_phase_entry;
  logic               w_timeout_hit;

  // A done is only honoured once its start pulse has gone low again.
  assign w_erase_acc  = (r_state == StErase)  && erase_done  && !r_erase_start;
  assign w_update_acc = (r_state == StUpdate) && update_done && !r_update_start;
  assign w_draw_acc   = (r_state == StDraw)   && draw_done   && !r_draw_start;
  assign w_done_acc   = w_erase_acc || w_update_acc || w_draw_acc;
  assign w_drop       = frame_tick && (r_state != StIdle) && !w_draw_acc;

`ifdef PHASE_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout_hit = (r_state != StIdle) && !w_done_acc &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset || w_phase_entry || (r_state == StIdle)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout_hit = 1'b0;
  assign w_unused_cfg  = ^{32'(TIMEOUT_CYCLES), 32'(TO_W)};
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (frame_tick) w_state_next = StErase;
      end
      StErase: begin
        if (w_erase_acc)        w_state_next = StUpdate;
        else if (w_timeout_hit) w_state_next = StIdle;
      end
      StUpdate: begin
        if (w_update_acc)       w_state_next = StDraw;
        else if (w_timeout_hit) w_state_next = StIdle;
      end
      StDraw: begin
        // A tick coinciding with draw completion chains straight into the next frame.
        if (w_draw_acc)         w_state_next = frame_tick ? StErase : StIdle;
        else if (w_timeout_hit) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_phase_entry     = (w_state_next != r_state) && (w_state_next != StIdle);
    w_erase_start_d   = w_phase_entry && (w_state_next == StErase);
    w_update_start_d  = w_phase_entry && (w_state_next == StUpdate);
    w_draw_start_d    = w_phase_entry && (w_state_next == StDraw);
    w_busy_d          = (w_state_next != StIdle);
    w_frame_count_d   = r_frame_count;
    if (w_draw_acc) begin
      w_frame_count_d = (r_frame_count == FRAME_W'(FRAMES_PER_SEC - 1)) ? '0 :
                        r_frame_count + FRAME_W'(1);
    end
    w_overrun_d       = w_drop;
    w_overrun_count_d = r_overrun_count;
    if (w_drop && (r_overrun_count != 8'hFF)) begin
      w_overrun_count_d = r_overrun_count + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_erase_start   <= 1'b0;
      r_update_start  <= 1'b0;
      r_draw_start    <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_count   <= '0;
      r_overrun       <= 1'b0;
      r_overrun_count <= '0;
      r_timeout       <= 1'b0;
    end else begin
      r_erase_start   <= w_erase_start_d;
      r_update_start  <= w_update_start_d;
      r_draw_start    <= w_draw_start_d;
      r_busy          <= w_busy_d;
      r_frame_count   <= w_frame_count_d;
      r_overrun       <= w_overrun_d;
      r_overrun_count <= w_overrun_count_d;
      r_timeout       <= w_timeout_hit;
    end
  end

  assign erase_start   = r_erase_start;
  assign update_start  = r_update_start;
  assign draw_start    = r_draw_start;
  assign busy          = r_busy;
  assign frame_count   = r_frame_count;
  assign overrun       = r_overrun;
  assign overrun_count = r_overrun_count;
  assign timeout       = r_timeout;

endmodule
